// File: rtl/imem_fetch_arbiter.sv
// Shares one fixed-latency instruction memory port between the fetch stage and a
// loader/debug port, with a single 8-byte line buffer that serves repeat accesses.
module imem_fetch_arbiter #(
    parameter int WAIT_CYCLES = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ack,
    input  logic        dbg_req,
    input  logic [15:0] dbg_addr,
    output logic        dbg_ack,
    output logic [63:0] rsp_line,
    output logic        busy,
    input  logic        flush,
    output logic [15:0] mem_address,
    input  logic [63:0] mem_ins
);

    // Handshake: a requester raises *_req with *_addr and holds both unchanged until
    // its *_ack pulses for exactly one cycle; rsp_line is valid in that ack cycle.
    // An ack is only ever issued from RESP, so a new request is taken in IDLE only.

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    logic [12:0]      tag_q, tag_d;
    logic             valid_q, valid_d;
    logic [63:0]      line_q, line_d;
    logic [15:0]      mem_address_q, mem_address_d;
    logic             nofill_q, nofill_d;

    logic             any_req;
    logic             sel;
    logic [12:0]      sel_line;
    logic             hit;

    // Byte offsets inside a line never affect which line is fetched.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{if_addr[2:0], dbg_addr[2:0]};

    always_comb begin
        any_req = if_req | dbg_req;
        if (if_req && dbg_req) begin
            sel = ~last_grant_q;
        end else begin
            sel = dbg_req;
        end
        sel_line = sel ? dbg_addr[15:3] : if_addr[15:3];
        hit      = valid_q && !flush && (sel_line == tag_q);
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        tag_d         = tag_q;
        valid_d       = valid_q;
        line_d        = line_q;
        mem_address_d = mem_address_q;
        nofill_d      = nofill_q;

        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    valid_d = 1'b0;
                end
                if (any_req) begin
                    grant_d      = sel;
                    last_grant_d = sel;
                    if (hit) begin
                        state_d = ST_RESP;
                    end else begin
                        mem_address_d = {sel_line, 3'b000};
                        cnt_d         = '0;
                        nofill_d      = 1'b0;
                        state_d       = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (flush) begin
                    nofill_d = 1'b1;
                end
                // The fill is still delivered after a flush, but is not kept as a hit line.
                if (cnt_q == CNT_LAST) begin
                    line_d  = mem_ins;
                    tag_d   = mem_address_q[15:3];
                    valid_d = !nofill_q && !flush;
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                if (flush) begin
                    valid_d = 1'b0;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            tag_q         <= '0;
            valid_q       <= 1'b0;
            line_q        <= '0;
            mem_address_q <= '0;
            nofill_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            tag_q         <= tag_d;
            valid_q       <= valid_d;
            line_q        <= line_d;
            mem_address_q <= mem_address_d;
            nofill_q      <= nofill_d;
        end
    end

    assign if_ack      = (state_q == ST_RESP) && !grant_q;
    assign dbg_ack     = (state_q == ST_RESP) && grant_q;
    assign busy        = (state_q != ST_IDLE);
    assign rsp_line    = line_q;
    assign mem_address = mem_address_q;

endmodule
